// File: rtl/history_out_if.sv
// Bus between the copy engine / output FIFO side and the history_out stage.
interface history_out_if #(
    parameter int HIST_AW = 11,
    parameter int OUT_W   = 32
);
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic [HIST_AW-1:0] read_address;
    logic [7:0]         read_data;
    logic [HIST_AW-1:0] write_address;
    logic [OUT_W-1:0]   fo_data;
    logic [3:0]         fo_be;
    logic               fo_wr;
    logic               fo_full;
    logic               all_end;
    logic               flush_done;
    logic               overflow;

    // Upstream decoder plus output FIFO status.
    modport master (
        output byte_in, byte_valid, read_address, fo_full, all_end,
        input  read_data, write_address, fo_data, fo_be, fo_wr, flush_done, overflow
    );

    // The history_out stage itself.
    modport slave (
        input  byte_in, byte_valid, read_address, fo_full, all_end,
        output read_data, write_address, fo_data, fo_be, fo_wr, flush_done, overflow
    );
endinterface

// File: rtl/history_out.sv
// LZS decoder output stage: history RAM write/read with bypass, 4-byte
// packing, one-word pending register for FIFO backpressure, and flush.
module history_out #(
    parameter int HIST_AW = 11,
    parameter int OUT_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    history_out_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    localparam logic [HIST_AW-1:0] ADDR_ONE = HIST_AW'(1);

    state_t             state, state_nx;
    logic [7:0]         mem [0:(1<<HIST_AW)-1];
    logic [HIST_AW-1:0] waddr;
    logic [HIST_AW-1:0] next_addr;
    logic [7:0]         rdata;
    logic [1:0]         cnt;
    logic [7:0]         lane0, lane1, lane2;
    logic               hold_valid;
    logic [OUT_W-1:0]   hold_data;
    logic [3:0]         hold_be;
    logic               ovf;
    logic               accept;
    logic               complete;
    logic               drain;
    logic               load_partial;
    logic [3:0]         partial_be;

    // Bytes are only taken while running; FLUSH and DONE ignore byte_valid.
    assign accept    = bus.byte_valid && (state == RUN);
    assign next_addr = waddr + ADDR_ONE;
    assign complete  = accept && (cnt == 2'd3);
    // The held word goes out in any cycle the FIFO can take it, so fo_wr
    // can never coincide with fo_full.
    assign drain     = hold_valid && !bus.fo_full;

    // Byte enables for a partial word: low lanes only.
    always_comb begin
        partial_be = 4'b0000;
        case (cnt)
            2'd1:    partial_be = 4'b0001;
            2'd2:    partial_be = 4'b0011;
            2'd3:    partial_be = 4'b0111;
            default: partial_be = 4'b0000;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // FSM next state: flush drains the held word, then emits any partial word.
    always_comb begin
        state_nx     = state;
        load_partial = 1'b0;
        case (state)
            RUN: begin
                if (bus.all_end) state_nx = FLUSH;
            end
            FLUSH: begin
                if (hold_valid) begin
                    if (drain && (cnt == 2'd0)) state_nx = DONE;
                end else if (cnt != 2'd0) begin
                    load_partial = 1'b1;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // History RAM write port (contents survive reset).
    always_ff @(posedge clk) begin
        if (accept) mem[next_addr] <= bus.byte_in;
    end

    // Write pointer: points at the most recently written byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         waddr <= '1;
        else if (accept) waddr <= next_addr;
    end

    // Registered read with same-cycle write bypass for short-offset repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (accept && (bus.read_address == next_addr)) begin
            rdata <= bus.byte_in;
        end else begin
            rdata <= mem[bus.read_address];
        end
    end

    // Lane packing; lanes are cleared whenever a word leaves so partial
    // words carry zeros in unused lanes. Lane 3 is taken straight from byte_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            lane0 <= '0;
            lane1 <= '0;
            lane2 <= '0;
        end else if (load_partial || (state == DONE)) begin
            cnt   <= '0;
            lane0 <= '0;
            lane1 <= '0;
            lane2 <= '0;
        end else if (accept) begin
            case (cnt)
                2'd0: begin lane0 <= bus.byte_in; cnt <= 2'd1; end
                2'd1: begin lane1 <= bus.byte_in; cnt <= 2'd2; end
                2'd2: begin lane2 <= bus.byte_in; cnt <= 2'd3; end
                default: begin
                    lane0 <= '0;
                    lane1 <= '0;
                    lane2 <= '0;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Output/pending word register. A single register serves both roles:
    // a fresh word is issued from it the next cycle, or waits in it while
    // the FIFO is full. A word completing while it is still blocked is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_be    <= '0;
            ovf        <= 1'b0;
        end else begin
            if (complete && (!hold_valid || drain)) begin
                hold_valid <= 1'b1;
                hold_data  <= {bus.byte_in, lane2, lane1, lane0};
                hold_be    <= 4'b1111;
            end else if (load_partial) begin
                hold_valid <= 1'b1;
                hold_data  <= {8'h00, lane2, lane1, lane0};
                hold_be    <= partial_be;
            end else if (drain) begin
                hold_valid <= 1'b0;
                hold_be    <= '0;
            end
            if (complete && hold_valid && bus.fo_full) ovf <= 1'b1;
        end
    end

    assign bus.read_data     = rdata;
    assign bus.write_address = waddr;
    assign bus.fo_data       = hold_data;
    assign bus.fo_be         = hold_be;
    assign bus.fo_wr         = drain;
    assign bus.flush_done    = (state == DONE);
    assign bus.overflow      = ovf;
endmodule

// File: tb/tb_history_out.sv
// Self-checking bench for history_out: vector table, directed corner
// sequences, and a randomized run against a byte-stream reference model.
module tb_history_out;
    logic clk = 1'b0;
    logic rst = 1'b1;

    history_out_if #(.HIST_AW(11), .OUT_W(32)) bus ();

    history_out #(.HIST_AW(11), .OUT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        bv;
        logic [7:0]  b;
        logic        full;
        logic        endp;
        logic        exp_wr;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [10:0] exp_wa;
        logic        exp_done;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
    } word_t;

    vec_t        tbl[$];
    logic [7:0]  hist [2048];
    int          wa;
    word_t       expq[$];
    logic [7:0]  part[$];
    bit          flushing;
    int          fwait;
    logic [7:0]  exp_rd;
    bit          exp_rd_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic [10:0] ra,
                        input logic full, input logic endp);
        @(posedge clk);
        #1;
        bus.byte_valid   = bv;
        bus.byte_in      = b;
        bus.read_address = ra;
        bus.fo_full      = full;
        bus.all_end      = endp;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.byte_valid   = 1'b0;
        bus.byte_in      = 8'h00;
        bus.read_address = 11'h000;
        bus.fo_full      = 1'b0;
        bus.all_end      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] val(input int k);
        logic [31:0] t;
        t = k;
        return t[7:0] ^ t[15:8];
    endfunction

    // One randomized cycle: drive, compare against the model, then advance the model.
    task automatic rnd_cycle(input logic bv, input logic [7:0] b, input logic [10:0] ra,
                             input logic full, input logic endp);
        word_t w;
        logic [31:0] d;
        step(bv, b, ra, full, endp);
        if (bus.fo_wr) begin
            chk("rnd_wr_while_full", {31'b0, full}, 32'd0);
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rnd_unexpected_word: got 0x%0h, expected no write", bus.fo_data);
            end else begin
                w = expq.pop_front();
                chk("rnd_fo_data", bus.fo_data, w.data);
                chk("rnd_fo_be", {28'b0, bus.fo_be}, {28'b0, w.be});
            end
        end
        if (exp_rd_ok) chk("rnd_read_data", {24'b0, bus.read_data}, {24'b0, exp_rd});
        chk("rnd_write_address", {21'b0, bus.write_address}, wa);
        if (bus.flush_done) begin
            chk("rnd_done_expected", {31'b0, flushing}, 32'd1);
            chk("rnd_flush_drained", expq.size(), 32'd0);
            flushing = 1'b0;
        end else if (flushing) begin
            fwait++;
            if (fwait > 60) begin
                n_checks++;
                n_fail++;
                $display("FAIL rnd_flush_timeout: got no flush_done, expected within 60 cycles");
                flushing = 1'b0;
            end
        end
        if (bv) begin
            wa = (wa + 1) % 2048;
            hist[wa] = b;
            part.push_back(b);
            if (part.size() == 4) begin
                w.data = {part[3], part[2], part[1], part[0]};
                w.be   = 4'b1111;
                expq.push_back(w);
                part.delete();
            end
        end
        if (endp) begin
            if (part.size() > 0) begin
                d = '0;
                for (int i = 0; i < part.size(); i++) d[i*8 +: 8] = part[i];
                w.data = d;
                w.be   = 4'((1 << part.size()) - 1);
                expq.push_back(w);
                part.delete();
            end
            flushing = 1'b1;
            fwait    = 0;
        end
        exp_rd    = hist[ra];
        exp_rd_ok = 1'b1;
    endtask

    initial begin
        int nwr;
        logic full, bv, e;
        logic [7:0] rb;
        logic [10:0] ra;

        // ---------------- reset values ----------------
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_write_address", {21'b0, bus.write_address}, 32'h7FF);
        chk("rst_read_data", {24'b0, bus.read_data}, 32'h0);
        chk("rst_fo_data", bus.fo_data, 32'h0);
        chk("rst_fo_be", {28'b0, bus.fo_be}, 32'h0);
        chk("rst_fo_wr", {31'b0, bus.fo_wr}, 32'h0);
        chk("rst_flush_done", {31'b0, bus.flush_done}, 32'h0);
        chk("rst_overflow", {31'b0, bus.overflow}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- vector table ----------------
        //              bv  b      full end  wr  data          be       wa      done
        tbl.push_back('{1, 8'h41, 0, 0, 0, 32'h0,        4'h0, 11'h7FF, 0});
        tbl.push_back('{1, 8'h42, 0, 0, 0, 32'h0,        4'h0, 11'h000, 0});
        tbl.push_back('{1, 8'h43, 0, 0, 0, 32'h0,        4'h0, 11'h001, 0});
        tbl.push_back('{1, 8'h44, 0, 0, 0, 32'h0,        4'h0, 11'h002, 0});
        tbl.push_back('{1, 8'h45, 0, 0, 1, 32'h44434241, 4'hF, 11'h003, 0});
        tbl.push_back('{1, 8'h46, 0, 0, 0, 32'h0,        4'h0, 11'h004, 0});
        tbl.push_back('{1, 8'h47, 0, 0, 0, 32'h0,        4'h0, 11'h005, 0});
        tbl.push_back('{1, 8'h48, 0, 0, 0, 32'h0,        4'h0, 11'h006, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 32'h48474645, 4'hF, 11'h007, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 32'h0,        4'h0, 11'h007, 0});
        tbl.push_back('{1, 8'h01, 0, 0, 0, 32'h0,        4'h0, 11'h007, 0});
        tbl.push_back('{1, 8'h02, 0, 0, 0, 32'h0,        4'h0, 11'h008, 0});
        tbl.push_back('{1, 8'h03, 0, 0, 0, 32'h0,        4'h0, 11'h009, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 32'h0,        4'h0, 11'h00A, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0,        4'h0, 11'h00A, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 32'h00030201, 4'h7, 11'h00A, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0,        4'h0, 11'h00A, 1});
        tbl.push_back('{1, 8'h11, 0, 0, 0, 32'h0,        4'h0, 11'h00A, 0});
        tbl.push_back('{1, 8'h22, 0, 0, 0, 32'h0,        4'h0, 11'h00B, 0});
        tbl.push_back('{1, 8'h33, 0, 1, 0, 32'h0,        4'h0, 11'h00C, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0,        4'h0, 11'h00D, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 32'h00332211, 4'h7, 11'h00D, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0,        4'h0, 11'h00D, 1});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 32'h0,        4'h0, 11'h00D, 0});
        tbl.push_back('{1, 8'hEE, 0, 0, 0, 32'h0,        4'h0, 11'h00D, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0,        4'h0, 11'h00D, 1});
        tbl.push_back('{1, 8'hAA, 0, 0, 0, 32'h0,        4'h0, 11'h00D, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 32'h0,        4'h0, 11'h00E, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0,        4'h0, 11'h00E, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 32'h0,        4'h0, 11'h00E, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 32'h0,        4'h0, 11'h00E, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 1, 32'h000000AA, 4'h1, 11'h00E, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0,        4'h0, 11'h00E, 1});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 32'h0,        4'h0, 11'h00E, 0});
        foreach (tbl[i]) begin
            step(tbl[i].bv, tbl[i].b, 11'h000, tbl[i].full, tbl[i].endp);
            chk($sformatf("tbl%0d_fo_wr", i), {31'b0, bus.fo_wr}, {31'b0, tbl[i].exp_wr});
            if (tbl[i].exp_wr) begin
                chk($sformatf("tbl%0d_fo_data", i), bus.fo_data, tbl[i].exp_data);
                chk($sformatf("tbl%0d_fo_be", i), {28'b0, bus.fo_be}, {28'b0, tbl[i].exp_be});
            end
            chk($sformatf("tbl%0d_write_address", i), {21'b0, bus.write_address}, {21'b0, tbl[i].exp_wa});
            chk($sformatf("tbl%0d_flush_done", i), {31'b0, bus.flush_done}, {31'b0, tbl[i].exp_done});
        end

        // ---------------- read bypass ----------------
        do_reset();
        step(1, 8'h5A, 11'h000, 0, 0);
        step(1, 8'h33, 11'h001, 0, 0);
        step(0, 8'h00, 11'h000, 0, 0);
        chk("bypass_read_data", {24'b0, bus.read_data}, 32'h33);
        step(0, 8'h00, 11'h000, 0, 0);
        chk("ram_read_data", {24'b0, bus.read_data}, 32'h5A);

        // ---------------- stall while full ----------------
        do_reset();
        step(1, 8'h10, 11'h0, 0, 0);
        step(1, 8'h11, 11'h0, 0, 0);
        step(1, 8'h12, 11'h0, 0, 0);
        step(1, 8'h13, 11'h0, 1, 0);
        chk("stall_fo_wr_0", {31'b0, bus.fo_wr}, 32'h0);
        for (int i = 1; i < 5; i++) begin
            step(0, 8'h00, 11'h0, 1, 0);
            chk($sformatf("stall_fo_wr_%0d", i), {31'b0, bus.fo_wr}, 32'h0);
        end
        step(0, 8'h00, 11'h0, 0, 0);
        chk("stall_release_fo_wr", {31'b0, bus.fo_wr}, 32'h1);
        chk("stall_release_fo_data", bus.fo_data, 32'h13121110);
        chk("stall_release_fo_be", {28'b0, bus.fo_be}, 32'hF);
        chk("stall_overflow", {31'b0, bus.overflow}, 32'h0);

        // ---------------- overflow ----------------
        for (int i = 0; i < 8; i++) begin
            rb = (i < 4) ? 8'(8'h20 + i) : 8'(8'h30 + i - 4);
            step(1, rb, 11'h0, 1, 0);
            chk($sformatf("ovf_fill_fo_wr_%0d", i), {31'b0, bus.fo_wr}, 32'h0);
        end
        step(0, 8'h00, 11'h0, 1, 0);
        chk("ovf_set", {31'b0, bus.overflow}, 32'h1);
        step(0, 8'h00, 11'h0, 0, 0);
        chk("ovf_pending_fo_wr", {31'b0, bus.fo_wr}, 32'h1);
        chk("ovf_pending_fo_data", bus.fo_data, 32'h23222120);
        step(0, 8'h00, 11'h0, 0, 0);
        chk("ovf_dropped_fo_wr", {31'b0, bus.fo_wr}, 32'h0);
        chk("ovf_sticky", {31'b0, bus.overflow}, 32'h1);

        // ---------------- reset discards pending and partial ----------------
        for (int i = 0; i < 6; i++) begin
            rb = (i < 4) ? 8'(8'h40 + i) : 8'(8'h50 + i - 4);
            step(1, rb, 11'h0, 1, 0);
        end
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("arst_fo_wr", {31'b0, bus.fo_wr}, 32'h0);
        chk("arst_fo_be", {28'b0, bus.fo_be}, 32'h0);
        chk("arst_fo_data", bus.fo_data, 32'h0);
        chk("arst_overflow", {31'b0, bus.overflow}, 32'h0);
        chk("arst_write_address", {21'b0, bus.write_address}, 32'h7FF);
        chk("arst_read_data", {24'b0, bus.read_data}, 32'h0);
        chk("arst_flush_done", {31'b0, bus.flush_done}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 11'h0, 0, 0);
            chk($sformatf("arst_no_wr_%0d", i), {31'b0, bus.fo_wr}, 32'h0);
        end
        step(0, 8'h00, 11'h0, 0, 1);
        step(0, 8'h00, 11'h0, 0, 0);
        chk("arst_flush_no_wr", {31'b0, bus.fo_wr}, 32'h0);
        step(0, 8'h00, 11'h0, 0, 0);
        chk("arst_flush_done", {31'b0, bus.flush_done}, 32'h1);
        chk("arst_flush_done_no_wr", {31'b0, bus.fo_wr}, 32'h0);

        // ---------------- address wrap ----------------
        do_reset();
        nwr = 0;
        for (int k = 1; k <= 2050; k++) begin
            step(1, val(k), 11'h0, 0, 0);
            if (bus.fo_wr) nwr++;
            hist[(k - 1) % 2048] = val(k);
        end
        chk("wrap_word_count", nwr, 32'd512);
        step(0, 8'h00, 11'h000, 0, 0);
        chk("wrap_write_address", {21'b0, bus.write_address}, 32'h001);
        step(0, 8'h00, 11'h7FF, 0, 0);
        chk("wrap_read_000", {24'b0, bus.read_data}, {24'b0, val(2049)});
        step(0, 8'h00, 11'h000, 0, 0);
        chk("wrap_read_7FF", {24'b0, bus.read_data}, {24'b0, val(2048)});

        // ---------------- randomized run vs. byte-stream model ----------------
        do_reset();
        wa        = 2047;
        flushing  = 1'b0;
        fwait     = 0;
        exp_rd_ok = 1'b0;
        expq.delete();
        part.delete();
        for (int i = 0; i < 3000; i++) begin
            full = ($urandom % 4) == 0;
            if (flushing) begin
                bv = 1'b0;
                e  = 1'b0;
            end else begin
                bv = !full && (($urandom % 3) != 0);
                e  = ($urandom % 120) == 0;
            end
            rb = 8'($urandom);
            ra = 11'($urandom_range(0, 2047));
            rnd_cycle(bv, rb, ra, full, e);
        end
        for (int i = 0; i < 100; i++) if (flushing) rnd_cycle(0, 8'h00, 11'h0, 0, 0);
        rnd_cycle(0, 8'h00, 11'h0, 0, 1);
        for (int i = 0; i < 100; i++) if (flushing) rnd_cycle(0, 8'h00, 11'h0, 0, 0);
        chk("rnd_final_queue_empty", expq.size(), 32'd0);
        chk("rnd_final_overflow", {31'b0, bus.overflow}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
